channel_reg_bank: RTL
=====================

Name: channel_reg_bank

Overview:
Multi-channel successor to the single-channel config register block. It decodes the byte-wide host config write bus into per-channel shadow registers, then commits them atomically to active outputs. It also provides registered readback and a per-channel load-protect fault latch that gates channel enable. It sits between the host config bus decoder and the NUM_CH DDS/PRBS channel datapaths.

Parameters:
NUM_CH, 2, number of channels (1..16).
CH_W, 4, width of channel-select field; must satisfy 2^CH_W >= NUM_CH.
PROT_DELAY, 24999, consecutive CLK_LOW cycles with CH_LOAD_PROTECT low before the fault latches.
BITRATE_RST, 32'h0200_0000, reset value of the bit-rate shadow and active registers.

Ports:
CLK_LOW  in  1  sole clock
reset_n  in  1  asynchronous active-low reset
CH_CONFIG_WE  in  1  write strobe, one byte per cycle
CH_CONFIG_RE  in  1  read strobe
CH_CONFIG_CH  in  CH_W  channel select
CH_CONFIG_ADDR  in  8  register offset
CH_CONFIG_DATA  in  8  write data
CH_CONFIG_RDATA  out  8  read data
CH_CONFIG_RVALID  out  1  read data valid
CH_LOAD_PROTECT  in  NUM_CH  per-channel load sense, low = overload
CH_LOAD_PROTECT_STATE  out  NUM_CH  latched fault
CH_ON_OFF  out  NUM_CH  channel enable, fault-gated
CH_CNT_ATTEN  out  4*NUM_CH  attenuator code
STAND_FREQ_INC  out  48*NUM_CH  active DDS phase increment
PRBS_PN_SELECT  out  4*NUM_CH  PN order
PRBS_BIT_RATE  out  32*NUM_CH  active bit-rate increment
PRBS_EDGE_TIME  out  8*NUM_CH  edge time
PRBS_AMPLITUDE  out  16*NUM_CH  active amplitude
PRBS_DC_OFFSET  out  16*NUM_CH  active DC offset
CH_UPDATE  out  NUM_CH  one-cycle commit pulse
(Channel c occupies bits [c*W +: W] of every bus.)

Behaviour:
- Reset values: all outputs 0, except PRBS_BIT_RATE and its shadow, which reset to BITRATE_RST. All shadows and counters reset to 0.
- Offset map, little-endian byte order:
  - 0x00 PN[3:0], direct.
  - 0x01-0x04 bit-rate shadow bytes 0-3.
  - 0x05 edge time, direct.
  - 0x06-0x07 amplitude shadow.
  - 0x08-0x09 DC offset shadow.
  - 0x0A-0x0F freq-inc shadow bytes 0-5.
  - 0x2D on/off request = DATA[0].
  - 0x31 ATTEN = DATA[3:0], direct.
  - 0x5A DATA[0]=1 clears the fault latch.
  - 0x5F commit: DATA[0] commits the selected channel; DATA[1] commits all channels.
  - All other offsets: writes ignored, reads return 0.
- Direct registers update on the clock edge after WE.
- Shadow writes never alter active outputs.
- Commit timing: the commit write is at edge N. At edge N+1, the active bit-rate, amplitude, DC offset and freq-inc registers load their shadows, and CH_UPDATE[c] pulses high for exactly one cycle.
- Commit with DATA[1:0]=0 does nothing. A commit with CH_CONFIG_CH >= NUM_CH plus DATA[1]=1 still commits all channels.
- CH_CONFIG_CH >= NUM_CH: all other writes are ignored; reads return 0.
- Readback latency: RE at edge N gives RDATA/RVALID at edge N+1, with RVALID high for one cycle.
  - Shadow offsets return the shadow byte.
  - Direct offsets return the register, zero-extended.
  - 0x2D returns the on/off request.
  - 0x5A returns {7'b0, fault}.
  - When RVALID is low, RDATA holds its last value.
- Simultaneous WE and RE: both are honoured. The read returns the pre-write value.
- Protect counter per channel:
  - Clears to 0 while CH_LOAD_PROTECT[c]=1.
  - Increments while the input is 0 and saturates at PROT_DELAY.
  - When the counter equals PROT_DELAY, the fault latch sets on the next edge.
  - A glitch high of one cycle restarts the count.
- Fault clear (0x5A write) is a one-shot event. If the set condition holds in the same cycle, set wins, so the latch re-asserts while the overload persists.
- CH_ON_OFF[c] is a registered (one-cycle) version of on/off request AND NOT fault.
- Reset mid-operation: everything returns to reset values immediately, and any pending commit or read is discarded.

Test Plan:
- Reset release -> all outputs 0 except PRBS_BIT_RATE = 0x02000000 per channel; RVALID=0.
- Ch1 writes 0x01..0x04 = 78,56,34,12 -> PRBS_BIT_RATE[ch1] unchanged. Then commit 0x5F=0x01 -> ch1 = 0x12345678 one cycle later with CH_UPDATE=2'b10 for one cycle; ch0 unchanged.
- Ch0 writes freq-inc 0x0A..0x0F = 01..06 and ch1 writes amplitude 0xBEEF. Then 0x5F=0x02 -> both channels update in the same cycle, CH_UPDATE=2'b11, STAND_FREQ_INC[ch0] = 0x060504030201.
- PROT_DELAY=10, ch0 on, CH_LOAD_PROTECT[0] held low -> fault=1 and CH_ON_OFF[0]=0 after 11-12 cycles. A single-cycle high glitch at count 5 delays the fault. A clear while still low -> fault stays 1; clear after release -> fault 0 and CH_ON_OFF[0] returns to 1.
- Read ch1 offset 0x03 after writing 0x34 -> RDATA=0x34, RVALID pulse one cycle after RE. Read ch=3 (NUM_CH=2) -> RDATA=0. Write+read same offset same cycle -> old value returned.
- Assert reset_n low between commit write and the update edge -> no CH_UPDATE pulse; all registers back to reset values asynchronously.

Source files
------------

// File: rtl/channel_reg_bank_if.sv
// Host config bus between the bus decoder (master) and channel_reg_bank (slave).
// One byte is written or read per cycle; read data comes back a cycle later.
interface channel_reg_bank_if #(
  parameter int CH_W = 4
);
  logic            CH_CONFIG_WE;
  logic            CH_CONFIG_RE;
  logic [CH_W-1:0] CH_CONFIG_CH;
  logic [7:0]      CH_CONFIG_ADDR;
  logic [7:0]      CH_CONFIG_DATA;
  logic [7:0]      CH_CONFIG_RDATA;
  logic            CH_CONFIG_RVALID;

  modport master (
    output CH_CONFIG_WE, CH_CONFIG_RE, CH_CONFIG_CH, CH_CONFIG_ADDR, CH_CONFIG_DATA,
    input  CH_CONFIG_RDATA, CH_CONFIG_RVALID
  );

  modport slave (
    input  CH_CONFIG_WE, CH_CONFIG_RE, CH_CONFIG_CH, CH_CONFIG_ADDR, CH_CONFIG_DATA,
    output CH_CONFIG_RDATA, CH_CONFIG_RVALID
  );
endinterface

// File: rtl/channel_reg_bank.sv
// Per-channel config registers: shadow registers committed atomically to the
// active outputs, registered readback, and a load-protect fault latch per channel.
module channel_reg_bank #(
  parameter int          NUM_CH      = 2,
  parameter int          CH_W        = 4,
  parameter int          PROT_DELAY  = 24999,
  parameter logic [31:0] BITRATE_RST = 32'h0200_0000
) (
  input  logic                 CLK_LOW,
  input  logic                 reset_n,
  channel_reg_bank_if.slave    cfg,
  input  logic [NUM_CH-1:0]    CH_LOAD_PROTECT,
  output logic [NUM_CH-1:0]    CH_LOAD_PROTECT_STATE,
  output logic [NUM_CH-1:0]    CH_ON_OFF,
  output logic [4*NUM_CH-1:0]  CH_CNT_ATTEN,
  output logic [48*NUM_CH-1:0] STAND_FREQ_INC,
  output logic [4*NUM_CH-1:0]  PRBS_PN_SELECT,
  output logic [32*NUM_CH-1:0] PRBS_BIT_RATE,
  output logic [8*NUM_CH-1:0]  PRBS_EDGE_TIME,
  output logic [16*NUM_CH-1:0] PRBS_AMPLITUDE,
  output logic [16*NUM_CH-1:0] PRBS_DC_OFFSET,
  output logic [NUM_CH-1:0]    CH_UPDATE
);

  localparam int CNT_W = (PROT_DELAY < 1) ? 1 : $clog2(PROT_DELAY + 1);

  logic [3:0]       pn_q      [NUM_CH];
  logic [3:0]       pn_d      [NUM_CH];
  logic [7:0]       etime_q   [NUM_CH];
  logic [7:0]       etime_d   [NUM_CH];
  logic [3:0]       atten_q   [NUM_CH];
  logic [3:0]       atten_d   [NUM_CH];
  logic [31:0]      br_sh_q   [NUM_CH];
  logic [31:0]      br_sh_d   [NUM_CH];
  logic [31:0]      br_act_q  [NUM_CH];
  logic [31:0]      br_act_d  [NUM_CH];
  logic [15:0]      amp_sh_q  [NUM_CH];
  logic [15:0]      amp_sh_d  [NUM_CH];
  logic [15:0]      amp_act_q [NUM_CH];
  logic [15:0]      amp_act_d [NUM_CH];
  logic [15:0]      dc_sh_q   [NUM_CH];
  logic [15:0]      dc_sh_d   [NUM_CH];
  logic [15:0]      dc_act_q  [NUM_CH];
  logic [15:0]      dc_act_d  [NUM_CH];
  logic [47:0]      frq_sh_q  [NUM_CH];
  logic [47:0]      frq_sh_d  [NUM_CH];
  logic [47:0]      frq_act_q [NUM_CH];
  logic [47:0]      frq_act_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q     [NUM_CH];
  logic [CNT_W-1:0] cnt_d     [NUM_CH];

  logic [NUM_CH-1:0] on_req_q, on_req_d;
  logic [NUM_CH-1:0] fault_q, fault_d;
  logic [NUM_CH-1:0] on_q, on_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] upd_q, upd_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic [NUM_CH-1:0] wr_hit;
  logic [7:0]        rd_byte;

  // An out-of-range channel select never matches, so its writes fall away.
  always_comb begin
    wr_hit = '0;
    for (int c = 0; c < NUM_CH; c++)
      wr_hit[c] = cfg.CH_CONFIG_WE && (cfg.CH_CONFIG_CH == CH_W'(c));
  end

  always_comb begin
    pn_d     = pn_q;
    etime_d  = etime_q;
    atten_d  = atten_q;
    br_sh_d  = br_sh_q;
    amp_sh_d = amp_sh_q;
    dc_sh_d  = dc_sh_q;
    frq_sh_d = frq_sh_q;
    on_req_d = on_req_q;
    pend_d   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_hit[c]) begin
        case (cfg.CH_CONFIG_ADDR)
          8'h00: pn_d[c]            = cfg.CH_CONFIG_DATA[3:0];
          8'h01: br_sh_d[c][7:0]    = cfg.CH_CONFIG_DATA;
          8'h02: br_sh_d[c][15:8]   = cfg.CH_CONFIG_DATA;
          8'h03: br_sh_d[c][23:16]  = cfg.CH_CONFIG_DATA;
          8'h04: br_sh_d[c][31:24]  = cfg.CH_CONFIG_DATA;
          8'h05: etime_d[c]         = cfg.CH_CONFIG_DATA;
          8'h06: amp_sh_d[c][7:0]   = cfg.CH_CONFIG_DATA;
          8'h07: amp_sh_d[c][15:8]  = cfg.CH_CONFIG_DATA;
          8'h08: dc_sh_d[c][7:0]    = cfg.CH_CONFIG_DATA;
          8'h09: dc_sh_d[c][15:8]   = cfg.CH_CONFIG_DATA;
          8'h0A: frq_sh_d[c][7:0]   = cfg.CH_CONFIG_DATA;
          8'h0B: frq_sh_d[c][15:8]  = cfg.CH_CONFIG_DATA;
          8'h0C: frq_sh_d[c][23:16] = cfg.CH_CONFIG_DATA;
          8'h0D: frq_sh_d[c][31:24] = cfg.CH_CONFIG_DATA;
          8'h0E: frq_sh_d[c][39:32] = cfg.CH_CONFIG_DATA;
          8'h0F: frq_sh_d[c][47:40] = cfg.CH_CONFIG_DATA;
          8'h2D: on_req_d[c]        = cfg.CH_CONFIG_DATA[0];
          8'h31: atten_d[c]         = cfg.CH_CONFIG_DATA[3:0];
          8'h5F: pend_d[c]          = cfg.CH_CONFIG_DATA[0];
          default: ;
        endcase
      end
    end
    // Commit-all is honoured regardless of the channel select.
    if (cfg.CH_CONFIG_WE && (cfg.CH_CONFIG_ADDR == 8'h5F) && cfg.CH_CONFIG_DATA[1])
      pend_d = '1;
  end

  // Commit stage: active registers take their shadows one edge after the commit write.
  always_comb begin
    br_act_d  = br_act_q;
    amp_act_d = amp_act_q;
    dc_act_d  = dc_act_q;
    frq_act_d = frq_act_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pend_q[c]) begin
        br_act_d[c]  = br_sh_q[c];
        amp_act_d[c] = amp_sh_q[c];
        dc_act_d[c]  = dc_sh_q[c];
        frq_act_d[c] = frq_sh_q[c];
      end
    end
    upd_d = pend_q;
  end

  // Load protect: a clear is one-shot, and a pending set overrides it.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (CH_LOAD_PROTECT[c])
        cnt_d[c] = '0;
      else if (cnt_q[c] == CNT_W'(PROT_DELAY))
        cnt_d[c] = cnt_q[c];
      else
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
    end
    fault_d = fault_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_hit[c] && (cfg.CH_CONFIG_ADDR == 8'h5A) && cfg.CH_CONFIG_DATA[0])
        fault_d[c] = 1'b0;
      if (cnt_q[c] == CNT_W'(PROT_DELAY))
        fault_d[c] = 1'b1;
    end
    on_d = on_req_q & ~fault_q;
  end

  // Readback samples the pre-write state, so a same-cycle write is not visible.
  always_comb begin
    rd_byte = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg.CH_CONFIG_CH == CH_W'(c)) begin
        case (cfg.CH_CONFIG_ADDR)
          8'h00: rd_byte = {4'b0, pn_q[c]};
          8'h01: rd_byte = br_sh_q[c][7:0];
          8'h02: rd_byte = br_sh_q[c][15:8];
          8'h03: rd_byte = br_sh_q[c][23:16];
          8'h04: rd_byte = br_sh_q[c][31:24];
          8'h05: rd_byte = etime_q[c];
          8'h06: rd_byte = amp_sh_q[c][7:0];
          8'h07: rd_byte = amp_sh_q[c][15:8];
          8'h08: rd_byte = dc_sh_q[c][7:0];
          8'h09: rd_byte = dc_sh_q[c][15:8];
          8'h0A: rd_byte = frq_sh_q[c][7:0];
          8'h0B: rd_byte = frq_sh_q[c][15:8];
          8'h0C: rd_byte = frq_sh_q[c][23:16];
          8'h0D: rd_byte = frq_sh_q[c][31:24];
          8'h0E: rd_byte = frq_sh_q[c][39:32];
          8'h0F: rd_byte = frq_sh_q[c][47:40];
          8'h2D: rd_byte = {7'b0, on_req_q[c]};
          8'h31: rd_byte = {4'b0, atten_q[c]};
          8'h5A: rd_byte = {7'b0, fault_q[c]};
          default: ;
        endcase
      end
    end
    rvalid_d = cfg.CH_CONFIG_RE;
    rdata_d  = cfg.CH_CONFIG_RE ? rd_byte : rdata_q;
  end

  always_ff @(posedge CLK_LOW or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        pn_q[c]      <= '0;
        etime_q[c]   <= '0;
        atten_q[c]   <= '0;
        br_sh_q[c]   <= BITRATE_RST;
        br_act_q[c]  <= BITRATE_RST;
        amp_sh_q[c]  <= '0;
        amp_act_q[c] <= '0;
        dc_sh_q[c]   <= '0;
        dc_act_q[c]  <= '0;
        frq_sh_q[c]  <= '0;
        frq_act_q[c] <= '0;
        cnt_q[c]     <= '0;
      end
      on_req_q <= '0;
      fault_q  <= '0;
      on_q     <= '0;
      pend_q   <= '0;
      upd_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      pn_q      <= pn_d;
      etime_q   <= etime_d;
      atten_q   <= atten_d;
      br_sh_q   <= br_sh_d;
      br_act_q  <= br_act_d;
      amp_sh_q  <= amp_sh_d;
      amp_act_q <= amp_act_d;
      dc_sh_q   <= dc_sh_d;
      dc_act_q  <= dc_act_d;
      frq_sh_q  <= frq_sh_d;
      frq_act_q <= frq_act_d;
      cnt_q     <= cnt_d;
      on_req_q  <= on_req_d;
      fault_q   <= fault_d;
      on_q      <= on_d;
      pend_q    <= pend_d;
      upd_q     <= upd_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      CH_CNT_ATTEN[c*4 +: 4]     = atten_q[c];
      STAND_FREQ_INC[c*48 +: 48] = frq_act_q[c];
      PRBS_PN_SELECT[c*4 +: 4]   = pn_q[c];
      PRBS_BIT_RATE[c*32 +: 32]  = br_act_q[c];
      PRBS_EDGE_TIME[c*8 +: 8]   = etime_q[c];
      PRBS_AMPLITUDE[c*16 +: 16] = amp_act_q[c];
      PRBS_DC_OFFSET[c*16 +: 16] = dc_act_q[c];
    end
  end

  assign CH_LOAD_PROTECT_STATE = fault_q;
  assign CH_ON_OFF             = on_q;
  assign CH_UPDATE             = upd_q;
  assign cfg.CH_CONFIG_RDATA   = rdata_q;
  assign cfg.CH_CONFIG_RVALID  = rvalid_q;

endmodule
